rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: in_bitwidth, default 1, bit width of each requester's data word.
REQ-002 Parameter: in_inputs, default 16, number of requesters.
REQ-003 Parameter: log2ofin, default ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs), width of grant index.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: req_valid  input  in_inputs  bit i = requester i offers a word.
REQ-008 Port: req_data  input  in_bitwidth*in_inputs  word i at bits [i*in_bitwidth +: in_bitwidth].
REQ-009 Port: req_ready  output  in_inputs  bit i = word i accepted this cycle (combinational).
REQ-010 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-011 Port: out_data  output  in_bitwidth  registered selected word.
REQ-012 Port: out_ready  input  1  downstream consumes out_data this cycle when out_valid=1.
REQ-013 Port: grant_sel  output  log2ofin  registered index of requester that supplied out_data.

Function
REQ-014 Two states SHALL exist: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-015 A round-robin pointer ptr (log2ofin bits) SHALL hold the highest-priority index; search order ptr, ptr+1, ..., in_inputs-1, 0, ..., ptr-1.
REQ-016 winner SHALL be the first index in search order with req_valid=1; any_req = |req_valid.
REQ-017 Accept condition: accept = any_req && (state==IDLE || out_ready).
REQ-018 req_ready SHALL be one-hot at bit winner when accept=1, all-zero otherwise; never more than one bit set.
REQ-019 On accept, out_data SHALL load req_data slice winner, grant_sel SHALL load winner, and state SHALL be BUSY next cycle (latency 1 cycle, request to out_valid).
REQ-020 On accept, ptr SHALL load winner+1, wrapping in_inputs-1 to 0.
REQ-021 BUSY with out_ready=1 and any_req=1 SHALL consume and accept in the same cycle; out_valid stays 1 (throughput 1 word/cycle).
REQ-022 BUSY with out_ready=1 and any_req=0 SHALL transition to IDLE; out_data and grant_sel hold their last values.
REQ-023 BUSY with out_ready=0: out_data, grant_sel, ptr SHALL hold; req_ready=0.
REQ-024 IDLE with any_req=0: no state change; out_ready ignored.
REQ-025 A requester deasserting req_valid without acceptance SHALL lose nothing and leave ptr unchanged.
REQ-026 in_inputs=1: ptr and grant_sel SHALL remain 0; the block acts as a one-entry register slice.
REQ-027 Non-power-of-two in_inputs: ptr and grant_sel SHALL never take values >= in_inputs.
REQ-028 Any single requester held continuously valid SHALL be granted within in_inputs accepts (starvation-free).

Reset
REQ-029 While rst_n=0: state=IDLE, out_valid=0, out_data=0, grant_sel=0, ptr=0, req_ready=0, independent of clk.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; first accept after release follows search from index 0.

Verification (in_inputs=4, in_bitwidth=8)
REQ-031 Reset release, req_valid=4'b0000 for 5 cycles -> out_valid=0, req_ready=0, out_data=8'h00 throughout.
REQ-032 req_valid=4'b1111 constant, words 8'hA0..8'hA3, out_ready=1 -> grant_sel sequence 0,1,2,3,0, out_data A0,A1,A2,A3,A0, out_valid=1 every cycle after first.
REQ-033 Accept req 2 (8'h5C), then out_ready=0 for 3 cycles with req_valid=4'b0011 -> out_data holds 8'h5C, grant_sel=2, req_ready=0; on out_ready=1, req 3 is absent so grant_sel=0.
REQ-034 ptr=3, req_valid=4'b0101 -> winner 0 (wrap), next ptr=1; next winner 2.
REQ-035 BUSY, out_ready=1, req_valid=0 -> IDLE next cycle, out_valid=0, out_data retains last value.
REQ-036 rst_n pulled low mid-cycle while BUSY -> out_valid=0 immediately (asynchronous), ptr=0; after release with req_valid=4'b1010 -> grant_sel=1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding a one-entry registered output slice.
// The winning word is captured on accept; the pointer rotates past the winner.
module rr_mux_arbiter #(
    parameter int in_bitwidth = 1,
    parameter int in_inputs   = 16,
    parameter int log2ofin    = ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [in_inputs-1:0]             req_valid,
    input  logic [in_bitwidth*in_inputs-1:0] req_data,
    output logic [in_inputs-1:0]             req_ready,
    output logic                             out_valid,
    output logic [in_bitwidth-1:0]           out_data,
    input  logic                             out_ready,
    output logic [log2ofin-1:0]              grant_sel
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic [log2ofin-1:0]    r_ptr;
    logic [log2ofin-1:0]    r_grant;
    logic [in_bitwidth-1:0] r_data;

    logic [log2ofin-1:0]    w_winner;
    logic [log2ofin-1:0]    w_ptr_next;
    logic                   w_found;
    logic                   w_any;
    logic                   w_accept;
    logic [in_bitwidth-1:0] w_word;

    // Search from the pointer upward, wrapping at in_inputs (not at 2**log2ofin).
    always_comb begin
        int idx;
        idx      = 0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < in_inputs; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= in_inputs) begin
                idx = idx - in_inputs;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx[log2ofin-1:0];
            end
        end
    end

    assign w_any      = |req_valid;
    // rst_n gates accept so req_ready stays low throughout reset.
    assign w_accept   = rst_n && w_any && ((r_state == ST_IDLE) || out_ready);
    assign w_ptr_next = (int'(w_winner) == in_inputs - 1) ? '0 : w_winner + 1'b1;
    assign w_word     = req_data[int'(w_winner)*in_bitwidth +: in_bitwidth];

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < in_inputs; i++) begin
            req_ready[i] = w_accept && (int'(w_winner) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= ST_BUSY;
            r_ptr   <= w_ptr_next;
            r_grant <= w_winner;
            r_data  <= w_word;
        end else if ((r_state == ST_BUSY) && out_ready) begin
            r_state <= ST_IDLE;
        end
    end

    assign out_valid = (r_state == ST_BUSY);
    assign out_data  = r_data;
    assign grant_sel = r_grant;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter with 4 requesters of 8-bit words.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  grant_sel;

    int n_cmp;
    int n_err;

    logic [9:0] sb[$];
    logic       m_busy;
    int         m_ptr;
    logic [7:0] m_last_data;
    logic [1:0] m_last_grant;

    rr_mux_arbiter #(
        .in_bitwidth(8),
        .in_inputs  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .grant_sel(grant_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdl_win(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic rdy);
        int         w;
        logic       acc;
        logic [3:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
        #1;
        w         = mdl_win(v, m_ptr);
        acc       = (w >= 0) && (!m_busy || rdy);
        exp_ready = acc ? (4'b0001 << w) : 4'b0000;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        if (m_busy) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, sb[0][7:0]});
                chk("grant_sel", {30'd0, grant_sel}, {30'd0, sb[0][9:8]});
                if (rdy) void'(sb.pop_front());
            end
        end else begin
            chk("idle_data", {24'd0, out_data}, {24'd0, m_last_data});
            chk("idle_grant", {30'd0, grant_sel}, {30'd0, m_last_grant});
        end
        if (acc) begin
            m_last_data  = d[w*8 +: 8];
            m_last_grant = w[1:0];
            sb.push_back({m_last_grant, m_last_data});
            m_ptr  = (w + 1) % 4;
            m_busy = 1'b1;
        end else if (m_busy && rdy) begin
            m_busy = 1'b0;
        end
    endtask

    // Reset is asserted away from any clock edge to exercise the asynchronous path.
    task automatic async_reset();
        @(posedge clk);
        #2;
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_grant", {30'd0, grant_sel}, 32'd0);
        m_busy       = 1'b0;
        m_ptr        = 0;
        m_last_data  = 8'h00;
        m_last_grant = 2'd0;
        sb.delete();
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dw;
        n_cmp        = 0;
        n_err        = 0;
        m_busy       = 1'b0;
        m_ptr        = 0;
        m_last_data  = 8'h00;
        m_last_grant = 2'd0;
        rst_n        = 1'b0;
        req_valid    = 4'b0000;
        req_data     = 32'd0;
        out_ready    = 1'b0;
        async_reset();

        for (int i = 0; i < 5; i++) cycle(4'b0000, 32'hDEADBEEF, i[0]);

        dw = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 6; i++) cycle(4'b1111, dw, 1'b1);
        cycle(4'b0000, dw, 1'b1);
        cycle(4'b0000, dw, 1'b1);

        async_reset();
        cycle(4'b0100, {8'h11, 8'h5C, 8'h22, 8'h33}, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0011, {8'h44, 8'h55, 8'h66, 8'h77}, 1'b0);
        cycle(4'b0011, {8'h44, 8'h55, 8'h66, 8'h77}, 1'b1);
        cycle(4'b0000, 32'd0, 1'b1);

        async_reset();
        cycle(4'b0100, {8'h0D, 8'h0C, 8'h0B, 8'h0A}, 1'b1);
        cycle(4'b0101, {8'h1D, 8'h1C, 8'h1B, 8'h1A}, 1'b1);
        cycle(4'b0101, {8'h2D, 8'h2C, 8'h2B, 8'h2A}, 1'b1);
        cycle(4'b0000, 32'd0, 1'b1);
        cycle(4'b0000, 32'd0, 1'b0);

        cycle(4'b0001, {8'hF3, 8'hF2, 8'hF1, 8'hF0}, 1'b0);
        cycle(4'b0010, {8'hF3, 8'hF2, 8'hF1, 8'hF0}, 1'b0);
        async_reset();
        cycle(4'b1010, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, 1'b0);
        cycle(4'b0000, 32'd0, 1'b0);
        cycle(4'b0000, 32'd0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) cycle(4'b0000, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
